// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Divide-by-zero and signed overflow complete on a one-cycle fast path.
//
// state  | meaning
// S_IDLE | waiting for a divide op; fast-path cases resolve here
// S_CALC | one quotient bit per cycle, XLEN cycles
// S_DONE | result valid for one cycle, pipeline released
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_result;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_valid;
  logic            r_busy;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN:0]   w_shifted;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[XLEN-1];
  assign w_b_neg  = w_signed & i_b[XLEN-1];
  assign w_a_abs  = w_a_neg ? -i_a : i_a;
  assign w_b_abs  = w_b_neg ? -i_b : i_b;
  assign w_b_zero = (i_b == '0);
  assign w_ovf    = w_signed & (i_a == INT_MIN) & (i_b == '1);

  // Restoring step: a borrow out of the trial subtract means the divisor does not fit.
  assign w_shifted  = {r_rem, r_quo[XLEN-1]};
  assign w_trial    = w_shifted - {1'b0, r_div};
  assign w_rem_next = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
  assign w_q_fix    = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_is_rem <= i_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div    <= w_b_abs;
            r_busy   <= 1'b1;
            if (w_b_zero) begin
              r_result <= i_op[1] ? i_a : '1;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= i_op[1] ? '0 : INT_MIN;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= CNT_INIT;
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_result <= r_is_rem ? w_r_fix : w_q_fix;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Accepting a start must freeze the front of the pipeline in the same cycle.
  assign o_stall  = ((r_state == S_IDLE) & i_start & ~i_flush) | (r_state == S_CALC);
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV32M reference.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] last_res = '0;

  ex_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic sgn;
    sgn = (o[0] == 1'b0);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'd0:    return $signed(x) / $signed(y);
      2'd1:    return x / y;
      2'd2:    return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (o[0] == 1'b0 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // start stays high with scrambled operands after acceptance: the unit must ignore it.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp;
    int n_edges, n_stall, exp_lat;
    bit seen;
    exp = ref_div(o, x, y);
    exp_lat = is_fast(o, x, y) ? 1 : 33;
    n_edges = 0;
    n_stall = 0;
    seen = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    while (!seen && n_edges < 40) begin
      #1;
      if (stall) n_stall++;
      if (valid) seen = 1;
      else begin
        @(posedge clk);
        n_edges++;
        #1;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        @(negedge clk);
      end
    end
    check({tag, "/valid_seen"}, 32'(seen), 32'd1);
    check({tag, "/latency"}, 32'(n_edges), 32'(exp_lat));
    check({tag, "/stall_cycles"}, 32'(n_stall), 32'(exp_lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/busy_done"}, 32'(busy), 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "/valid_drop"}, 32'(valid), 32'd0);
    check({tag, "/busy_drop"}, 32'(busy), 32'd0);
    check({tag, "/held"}, result, exp);
    last_res = exp;
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid) hits++;
    end
    check({tag, "/no_valid"}, 32'(hits), 32'd0);
  endtask

  function automatic logic [31:0] pick_val(input int mode);
    case (mode)
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2;
    check("reset/valid", 32'(valid), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", 2'd0, 32'd7, 32'hFFFF_FFFE);
    run_op("div_5_0", 2'd0, 32'd5, 32'd0);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush ten cycles into CALC: aborted op must leave result untouched.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush/busy", 32'(busy), 32'd0);
    check("flush/valid", 32'(valid), 32'd0);
    check("flush/result", result, last_res);
    watch_no_valid("flush", 40);
    run_op("divu_9_3", 2'd1, 32'd9, 32'd3);

    // flush and start together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd50; b = 32'd5;
    #1 check("flush_start/stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("flush_start/busy", 32'(busy), 32'd0);
    watch_no_valid("flush_start", 40);

    // Async reset twenty cycles into CALC.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'h0000_FFFF; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset/valid", 32'(valid), 32'd0);
    check("midreset/busy", 32'(busy), 32'd0);
    check("midreset/result", result, 32'd0);
    check("midreset/stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_valid("midreset", 40);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick_val($urandom_range(0, 7));
      rb = pick_val($urandom_range(0, 7));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
